// File: rtl/dataram_arbiter_pkg.sv
// Shared widths, state encoding and helpers for the SPRAM data-memory arbiter.
// Imported by the arbiter top and its burst address generator.
package dataram_arbiter_pkg;

  localparam int unsigned AW_DEF = 14;
  localparam int unsigned DW_DEF = 16;
  localparam int unsigned LW_DEF = 8;
  localparam int unsigned MASK_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Nibble enables only reach the SPRAM on writes; reads must never mask.
  function automatic logic [MASK_W-1:0] write_mask(input logic we,
                                                   input logic [MASK_W-1:0] mask);
    return we ? mask : '0;
  endfunction

endpackage

// File: rtl/dataram_burst_gen.sv
// Burst address/beat counters for the auxiliary read engine, plus a flag
// remembering whether the previous SPRAM slot carried a burst beat.
module dataram_burst_gen
  import dataram_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  input  logic          beat_i,
  output logic [AW-1:0] acnt_o,
  output logic          last_o,
  output logic          prev_beat_o
);

  logic [AW-1:0] acnt_q, acnt_d;
  logic [LW-1:0] bcnt_q, bcnt_d;
  logic          prev_beat_q, prev_beat_d;

  // load and beat never coincide: loads happen only while idle, beats only in a burst.
  always_comb begin
    acnt_d      = acnt_q;
    bcnt_d      = bcnt_q;
    prev_beat_d = beat_i;
    if (load_i) begin
      acnt_d = addr_i;
      bcnt_d = len_i;
    end else if (beat_i) begin
      acnt_d = acnt_q + AW'(1);   // wraps naturally at the top of the array
      bcnt_d = bcnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acnt_q      <= '0;
      bcnt_q      <= '0;
      prev_beat_q <= 1'b0;
    end else begin
      acnt_q      <= acnt_d;
      bcnt_q      <= bcnt_d;
      prev_beat_q <= prev_beat_d;
    end
  end

  assign acnt_o      = acnt_q;
  assign last_o      = (bcnt_q == '0);
  assign prev_beat_o = prev_beat_q;

endmodule

// File: rtl/dataram_arbiter.sv
// Shares one single-port SPRAM between the CPU data port and a read-burst
// engine: one access per clock, 1-cycle read return, CPU never starved.
module dataram_arbiter
  import dataram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LW       = LW_DEF,
  parameter bit          CPU_PRIO = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // CPU data port
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [AW-1:0]     cpu_addr_i,
  input  logic [DW-1:0]     cpu_wdata_i,
  input  logic [MASK_W-1:0] cpu_mask_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DW-1:0]     cpu_rdata_o,
  // auxiliary burst reader
  input  logic              aux_req_i,
  input  logic [AW-1:0]     aux_addr_i,
  input  logic [LW-1:0]     aux_len_i,
  output logic              aux_gnt_o,
  output logic              aux_busy_o,
  output logic              aux_rvalid_o,
  output logic [DW-1:0]     aux_rdata_o,
  output logic              aux_done_o,
  // SPRAM
  output logic [AW-1:0]     ram_addr_o,
  output logic [DW-1:0]     ram_wdata_o,
  output logic              ram_wren_o,
  output logic [MASK_W-1:0] ram_maskwren_o,
  output logic              ram_cs_o,
  input  logic [DW-1:0]     ram_rdata_i
);

  arb_state_e state_q, state_d;
  logic       cpu_gnt, aux_gnt, beat;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       aux_rvalid_q, aux_rvalid_d;
  logic       aux_done_q, aux_done_d;
  logic [AW-1:0] acnt;
  logic       last_beat;
  logic       prev_beat;

  dataram_burst_gen #(
    .AW(AW),
    .LW(LW)
  ) u_burst_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (aux_gnt),
    .addr_i     (aux_addr_i),
    .len_i      (aux_len_i),
    .beat_i     (beat),
    .acnt_o     (acnt),
    .last_o     (last_beat),
    .prev_beat_o(prev_beat)
  );

  // Slot arbitration: the acceptance cycle still belongs to the CPU, so the
  // first beat can only issue once the burst state is entered.
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    beat    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_gnt = cpu_req_i;
        aux_gnt = aux_req_i;
        if (aux_req_i) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        cpu_gnt = CPU_PRIO ? cpu_req_i : (cpu_req_i && prev_beat);
        beat    = !cpu_gnt;
        if (beat && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SPRAM port mux; everything is held at zero in an unused slot.
  always_comb begin
    ram_addr_o     = '0;
    ram_wdata_o    = '0;
    ram_wren_o     = 1'b0;
    ram_maskwren_o = '0;
    if (cpu_gnt) begin
      ram_addr_o     = cpu_addr_i;
      ram_wdata_o    = cpu_wdata_i;
      ram_wren_o     = cpu_we_i;
      ram_maskwren_o = write_mask(cpu_we_i, cpu_mask_i);
    end else if (beat) begin
      ram_addr_o = acnt;
    end
  end

  assign cpu_rvalid_d = cpu_gnt && !cpu_we_i;
  assign aux_rvalid_d = beat;
  assign aux_done_d   = beat && last_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cpu_rvalid_q <= 1'b0;
      aux_rvalid_q <= 1'b0;
      aux_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_done_q   <= aux_done_d;
    end
  end

  assign ram_cs_o     = cpu_gnt || beat;
  assign cpu_gnt_o    = cpu_gnt;
  assign aux_gnt_o    = aux_gnt;
  assign aux_busy_o   = (state_q == ST_BURST);
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign aux_rvalid_o = aux_rvalid_q;
  assign aux_done_o   = aux_done_q;
  assign cpu_rdata_o  = ram_rdata_i;
  assign aux_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Directed bench for dataram_arbiter: instance 0 alternates slots, instance 1
// gives the CPU absolute priority; both share stimulus and own an SPRAM model.
module tb_dataram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [3:0]  cpu_mask;
  logic        aux_req;
  logic [13:0] aux_addr;
  logic [7:0]  aux_len;

  logic        cpu_gnt [2];
  logic        cpu_rvalid [2];
  logic [15:0] cpu_rdata [2];
  logic        aux_gnt [2];
  logic        aux_busy [2];
  logic        aux_rvalid [2];
  logic [15:0] aux_rdata [2];
  logic        aux_done [2];
  logic [13:0] ram_addr [2];
  logic [15:0] ram_wdata [2];
  logic        ram_wren [2];
  logic [3:0]  ram_mask [2];
  logic        ram_cs [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten SPRAM words read back as {2'b10, address}.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] mem [0:16383];
    bit          written [0:16383];
    logic [15:0] rd_q;
    logic [15:0] cur;

    dataram_arbiter #(
      .AW(14), .DW(16), .LW(8), .CPU_PRIO(gi == 1)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .cpu_req_i     (cpu_req),
      .cpu_we_i      (cpu_we),
      .cpu_addr_i    (cpu_addr),
      .cpu_wdata_i   (cpu_wdata),
      .cpu_mask_i    (cpu_mask),
      .cpu_gnt_o     (cpu_gnt[gi]),
      .cpu_rvalid_o  (cpu_rvalid[gi]),
      .cpu_rdata_o   (cpu_rdata[gi]),
      .aux_req_i     (aux_req),
      .aux_addr_i    (aux_addr),
      .aux_len_i     (aux_len),
      .aux_gnt_o     (aux_gnt[gi]),
      .aux_busy_o    (aux_busy[gi]),
      .aux_rvalid_o  (aux_rvalid[gi]),
      .aux_rdata_o   (aux_rdata[gi]),
      .aux_done_o    (aux_done[gi]),
      .ram_addr_o    (ram_addr[gi]),
      .ram_wdata_o   (ram_wdata[gi]),
      .ram_wren_o    (ram_wren[gi]),
      .ram_maskwren_o(ram_mask[gi]),
      .ram_cs_o      (ram_cs[gi]),
      .ram_rdata_i   (rd_q)
    );

    always @(posedge clk) begin
      if (ram_cs[gi]) begin
        cur = written[ram_addr[gi]] ? mem[ram_addr[gi]] : {2'b10, ram_addr[gi]};
        if (ram_wren[gi]) begin
          for (int n = 0; n < 4; n++) begin
            if (ram_mask[gi][n]) cur[n*4 +: 4] = ram_wdata[gi][n*4 +: 4];
          end
          mem[ram_addr[gi]]     <= cur;
          written[ram_addr[gi]] <= 1'b1;
        end else begin
          rd_q <= cur;
        end
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (!aux_busy[0] && !aux_busy[1] && !aux_rvalid[0] && !aux_rvalid[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_mask = '0;
    aux_req = 0; aux_addr = '0; aux_len = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_busy[d] !== 1'b0) begin errors++; $display("FAIL rst_busy dut%0d got=%b exp=0", d, aux_busy[d]); end
      checks++; if (cpu_rvalid[d] !== 1'b0) begin errors++; $display("FAIL rst_cpu_rvalid dut%0d got=%b exp=0", d, cpu_rvalid[d]); end
      checks++; if (aux_rvalid[d] !== 1'b0 || aux_done[d] !== 1'b0) begin errors++; $display("FAIL rst_aux dut%0d got rvalid=%b done=%b exp 0/0", d, aux_rvalid[d], aux_done[d]); end
      checks++; if (ram_cs[d] !== 1'b0) begin errors++; $display("FAIL rst_cs dut%0d got=%b exp=0", d, ram_cs[d]); end
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_cpu_rw();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 16'hBEEF; cpu_mask = 4'hF;
    #1;
    $display("t1 cpu write addr=0010 data=beef");
    for (int d = 0; d < 2; d++) begin
      checks++; if (cpu_gnt[d] !== 1'b1) begin errors++; $display("FAIL t1_wr_gnt dut%0d got=%b exp=1", d, cpu_gnt[d]); end
      checks++; if (ram_wren[d] !== 1'b1 || ram_mask[d] !== 4'hF) begin errors++; $display("FAIL t1_wr_en dut%0d got wren=%b mask=%h exp 1/f", d, ram_wren[d], ram_mask[d]); end
      checks++; if (ram_addr[d] !== 14'h0010 || ram_wdata[d] !== 16'hBEEF) begin errors++; $display("FAIL t1_wr_bus dut%0d got addr=%h data=%h exp 0010/beef", d, ram_addr[d], ram_wdata[d]); end
    end
    @(negedge clk);
    cpu_we = 0; cpu_wdata = '0;
    #1;
    $display("t1 cpu read addr=0010");
    for (int d = 0; d < 2; d++) begin
      checks++; if (cpu_gnt[d] !== 1'b1 || ram_cs[d] !== 1'b1) begin errors++; $display("FAIL t1_rd_gnt dut%0d got gnt=%b cs=%b exp 1/1", d, cpu_gnt[d], ram_cs[d]); end
      checks++; if (ram_wren[d] !== 1'b0 || ram_mask[d] !== 4'h0) begin errors++; $display("FAIL t1_rd_en dut%0d got wren=%b mask=%h exp 0/0", d, ram_wren[d], ram_mask[d]); end
      checks++; if (cpu_rvalid[d] !== 1'b0) begin errors++; $display("FAIL t1_wr_norvalid dut%0d got=%b exp=0", d, cpu_rvalid[d]); end
    end
    @(negedge clk);
    cpu_req = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (cpu_gnt[d] !== 1'b0 || ram_cs[d] !== 1'b0) begin errors++; $display("FAIL t1_idle dut%0d got gnt=%b cs=%b exp 0/0", d, cpu_gnt[d], ram_cs[d]); end
      checks++; if (cpu_rvalid[d] !== 1'b1 || cpu_rdata[d] !== 16'hBEEF) begin errors++; $display("FAIL t1_rdata dut%0d got rvalid=%b data=%h exp 1/beef", d, cpu_rvalid[d], cpu_rdata[d]); end
    end
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (cpu_rvalid[d] !== 1'b0) begin errors++; $display("FAIL t1_rvalid_clr dut%0d got=%b exp=0", d, cpu_rvalid[d]); end
    end
  endtask

  task automatic test_burst_wrap();
    logic [13:0] exp_a [4];
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    @(negedge clk);
    aux_req = 1; aux_addr = 14'h3FFE; aux_len = 8'd3;
    #1;
    $display("t2 burst addr=3ffe len=3");
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_gnt[d] !== 1'b1 || aux_busy[d] !== 1'b0 || ram_cs[d] !== 1'b0) begin errors++; $display("FAIL t2_accept dut%0d got gnt=%b busy=%b cs=%b exp 1/0/0", d, aux_gnt[d], aux_busy[d], ram_cs[d]); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      aux_req = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (aux_busy[d] !== 1'b1 || ram_cs[d] !== 1'b1 || ram_addr[d] !== exp_a[k]) begin errors++; $display("FAIL t2_beat dut%0d k=%0d got busy=%b cs=%b addr=%h exp 1/1/%h", d, k, aux_busy[d], ram_cs[d], ram_addr[d], exp_a[k]); end
        checks++; if (aux_rvalid[d] !== (k > 0) || aux_done[d] !== 1'b0) begin errors++; $display("FAIL t2_rvalid dut%0d k=%0d got rvalid=%b done=%b exp %b/0", d, k, aux_rvalid[d], aux_done[d], (k > 0)); end
        if (k > 0) begin
          checks++; if (aux_rdata[d] !== {2'b10, exp_a[k-1]}) begin errors++; $display("FAIL t2_rdata dut%0d k=%0d got=%h exp=%h", d, k, aux_rdata[d], {2'b10, exp_a[k-1]}); end
        end
      end
    end
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_busy[d] !== 1'b0 || ram_cs[d] !== 1'b0) begin errors++; $display("FAIL t2_end dut%0d got busy=%b cs=%b exp 0/0", d, aux_busy[d], ram_cs[d]); end
      checks++; if (aux_rvalid[d] !== 1'b1 || aux_done[d] !== 1'b1 || aux_rdata[d] !== 16'h8001) begin errors++; $display("FAIL t2_done dut%0d got rvalid=%b done=%b data=%h exp 1/1/8001", d, aux_rvalid[d], aux_done[d], aux_rdata[d]); end
    end
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_rvalid[d] !== 1'b0 || aux_done[d] !== 1'b0) begin errors++; $display("FAIL t2_clr dut%0d got rvalid=%b done=%b exp 0/0", d, aux_rvalid[d], aux_done[d]); end
    end
  endtask

  task automatic test_alternate();
    int          beats_seen;
    bit          ok;
    logic [13:0] ea;
    logic [15:0] ed;
    beats_seen = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
    aux_req = 1; aux_addr = 14'h0200; aux_len = 8'd7;
    #1;
    $display("t3 burst addr=0200 len=7 with cpu reads, alternating");
    checks++; if (cpu_gnt[0] !== 1'b1 || aux_gnt[0] !== 1'b1) begin errors++; $display("FAIL t3_accept got cpu_gnt=%b aux_gnt=%b exp 1/1", cpu_gnt[0], aux_gnt[0]); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      aux_req = 0;
      #1;
      checks++; if (cpu_gnt[0] !== k[0]) begin errors++; $display("FAIL t3_slot k=%0d got cpu_gnt=%b exp=%b", k, cpu_gnt[0], k[0]); end
      if (!k[0]) begin
        ea = 14'(14'h0200 + k / 2);
        checks++; if (ram_addr[0] !== ea) begin errors++; $display("FAIL t3_addr k=%0d got=%h exp=%h", k, ram_addr[0], ea); end
      end
      checks++; if (aux_rvalid[0] !== k[0] || aux_done[0] !== (k == 15) || aux_busy[0] !== (k < 15)) begin errors++; $display("FAIL t3_flags k=%0d got rvalid=%b done=%b busy=%b", k, aux_rvalid[0], aux_done[0], aux_busy[0]); end
      if (aux_rvalid[0]) begin
        ed = 16'(16'h8200 + beats_seen);
        checks++; if (aux_rdata[0] !== ed) begin errors++; $display("FAIL t3_rdata k=%0d got=%h exp=%h", k, aux_rdata[0], ed); end
        beats_seen++;
      end
      checks++; if (cpu_rvalid[0] !== !k[0]) begin errors++; $display("FAIL t3_cpu_rvalid k=%0d got=%b exp=%b", k, cpu_rvalid[0], !k[0]); end
      if (cpu_rvalid[0]) begin
        checks++; if (cpu_rdata[0] !== 16'hBEEF) begin errors++; $display("FAIL t3_cpu_rdata k=%0d got=%h exp=beef", k, cpu_rdata[0]); end
      end
    end
    checks++; if (beats_seen != 8) begin errors++; $display("FAIL t3_beat_count got=%0d exp=8", beats_seen); end
    @(negedge clk);
    cpu_req = 0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_wait_idle got busy=%b/%b exp idle", aux_busy[0], aux_busy[1]); end
  endtask

  task automatic test_cpu_prio();
    logic [13:0] t4_addr [13];
    bit          t4_hi [13];
    bit          pb, ok;
    t4_addr = '{14'h0010, 14'h0010, 14'h0010, 14'h0200, 14'h0201, 14'h0010, 14'h0010,
                14'h0202, 14'h0203, 14'h0204, 14'h0205, 14'h0206, 14'h0207};
    t4_hi   = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
    aux_req = 1; aux_addr = 14'h0200; aux_len = 8'd7;
    #1;
    $display("t4 burst addr=0200 len=7 with cpu priority stalls");
    checks++; if (cpu_gnt[1] !== 1'b1 || aux_gnt[1] !== 1'b1) begin errors++; $display("FAIL t4_accept got cpu_gnt=%b aux_gnt=%b exp 1/1", cpu_gnt[1], aux_gnt[1]); end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      aux_req = 0;
      cpu_req = (k < 13) ? t4_hi[k] : 1'b0;
      #1;
      pb = (k == 0) ? 1'b0 : !t4_hi[k-1];
      if (k < 13) begin
        checks++; if (aux_busy[1] !== 1'b1 || ram_cs[1] !== 1'b1 || cpu_gnt[1] !== t4_hi[k] || ram_addr[1] !== t4_addr[k]) begin errors++; $display("FAIL t4_slot k=%0d got busy=%b cs=%b gnt=%b addr=%h exp 1/1/%b/%h", k, aux_busy[1], ram_cs[1], cpu_gnt[1], ram_addr[1], t4_hi[k], t4_addr[k]); end
        checks++; if (aux_done[1] !== 1'b0) begin errors++; $display("FAIL t4_early_done k=%0d got=%b exp=0", k, aux_done[1]); end
      end else begin
        checks++; if (aux_busy[1] !== 1'b0 || aux_done[1] !== 1'b1) begin errors++; $display("FAIL t4_done got busy=%b done=%b exp 0/1", aux_busy[1], aux_done[1]); end
      end
      checks++; if (aux_rvalid[1] !== pb) begin errors++; $display("FAIL t4_rvalid k=%0d got=%b exp=%b", k, aux_rvalid[1], pb); end
      if (pb) begin
        checks++; if (aux_rdata[1] !== {2'b10, t4_addr[k-1]}) begin errors++; $display("FAIL t4_rdata k=%0d got=%h exp=%h", k, aux_rdata[1], {2'b10, t4_addr[k-1]}); end
      end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_wait_idle got busy=%b/%b exp idle", aux_busy[0], aux_busy[1]); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
    aux_req = 1; aux_addr = 14'h0300; aux_len = 8'd1;
    #1;
    $display("t5 simultaneous cpu read and burst addr=0300 len=1");
    for (int d = 0; d < 2; d++) begin
      checks++; if (cpu_gnt[d] !== 1'b1 || aux_gnt[d] !== 1'b1 || ram_addr[d] !== 14'h0010) begin errors++; $display("FAIL t5_both dut%0d got cpu=%b aux=%b addr=%h exp 1/1/0010", d, cpu_gnt[d], aux_gnt[d], ram_addr[d]); end
    end
    @(negedge clk);
    cpu_req = 0; aux_addr = 14'h0400;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_gnt[d] !== 1'b0 || aux_busy[d] !== 1'b1 || ram_addr[d] !== 14'h0300) begin errors++; $display("FAIL t5_beat0 dut%0d got gnt=%b busy=%b addr=%h exp 0/1/0300", d, aux_gnt[d], aux_busy[d], ram_addr[d]); end
      checks++; if (cpu_rvalid[d] !== 1'b1 || cpu_rdata[d] !== 16'hBEEF) begin errors++; $display("FAIL t5_cpu_rdata dut%0d got rvalid=%b data=%h exp 1/beef", d, cpu_rvalid[d], cpu_rdata[d]); end
    end
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_gnt[d] !== 1'b0 || ram_addr[d] !== 14'h0301) begin errors++; $display("FAIL t5_beat1 dut%0d got gnt=%b addr=%h exp 0/0301", d, aux_gnt[d], ram_addr[d]); end
    end
    @(negedge clk);
    aux_req = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_busy[d] !== 1'b0 || aux_done[d] !== 1'b1 || aux_rdata[d] !== 16'h8301) begin errors++; $display("FAIL t5_done dut%0d got busy=%b done=%b data=%h exp 0/1/8301", d, aux_busy[d], aux_done[d], aux_rdata[d]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    aux_req = 1; aux_addr = 14'h0000; aux_len = 8'd7;
    repeat (3) begin
      @(negedge clk);
      aux_req = 0;
    end
    #1;
    $display("t6 reset after two beats of burst addr=0000 len=7");
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_rvalid[d] !== 1'b1 || aux_busy[d] !== 1'b1) begin errors++; $display("FAIL t6_pre dut%0d got rvalid=%b busy=%b exp 1/1", d, aux_rvalid[d], aux_busy[d]); end
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_busy[d] !== 1'b0 || aux_rvalid[d] !== 1'b0 || aux_done[d] !== 1'b0 || cpu_rvalid[d] !== 1'b0 || ram_cs[d] !== 1'b0 || aux_gnt[d] !== 1'b0) begin errors++; $display("FAIL t6_abort dut%0d got busy=%b rvalid=%b done=%b cs=%b exp all 0", d, aux_busy[d], aux_rvalid[d], aux_done[d], ram_cs[d]); end
    end
    repeat (2) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (aux_done[d] !== 1'b0 || aux_busy[d] !== 1'b0) begin errors++; $display("FAIL t6_held dut%0d got done=%b busy=%b exp 0/0", d, aux_done[d], aux_busy[d]); end
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    aux_req = 1; aux_addr = 14'h0100; aux_len = 8'd0;
    #1;
    $display("t6 burst addr=0100 len=0 after reset");
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_gnt[d] !== 1'b1) begin errors++; $display("FAIL t6_regnt dut%0d got=%b exp=1", d, aux_gnt[d]); end
    end
    @(negedge clk);
    aux_req = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_busy[d] !== 1'b1 || ram_addr[d] !== 14'h0100 || ram_cs[d] !== 1'b1) begin errors++; $display("FAIL t6_beat dut%0d got busy=%b addr=%h cs=%b exp 1/0100/1", d, aux_busy[d], ram_addr[d], ram_cs[d]); end
    end
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (aux_busy[d] !== 1'b0 || aux_rvalid[d] !== 1'b1 || aux_done[d] !== 1'b1 || aux_rdata[d] !== 16'h8100) begin errors++; $display("FAIL t6_done dut%0d got busy=%b rvalid=%b done=%b data=%h exp 0/1/1/8100", d, aux_busy[d], aux_rvalid[d], aux_done[d], aux_rdata[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_burst_wrap();
    test_alternate();
    test_cpu_prio();
    test_same_cycle();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dataram_arbiter.md
Name: dataram_arbiter

Overview:
- Shares the single-port 16K x 16 SPRAM data memory between two requesters.
- Requester one is the rj32 CPU data port: single read/write accesses.
- Requester two is an auxiliary read-burst engine, such as a VGA front-panel/framebuffer fetch or a debug dump.
- Issues at most one SPRAM access per clock. Routes read data back with fixed 1-cycle latency. Guarantees CPU progress during long bursts.

Parameters:
AW, 14, SPRAM word-address width
DW, 16, data width
LW, 8, burst length field width (bursts of 1..2^LW beats)
CPU_PRIO, 0, 0 = CPU and burst alternate slots under contention; 1 = CPU always wins the slot

Ports:
clock  in  1  system clock; all state on rising edge
nreset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  write data
cpu_mask  in  4  nibble write enables
cpu_gnt  out  1  combinational: CPU owns this cycle's slot
cpu_rvalid  out  1  read data valid (1 cycle after a read grant)
cpu_rdata  out  DW  read data
aux_req  in  1  burst request; held until aux_gnt
aux_addr  in  AW  burst start address
aux_len  in  LW  beats minus 1
aux_gnt  out  1  combinational: burst accepted this cycle
aux_busy  out  1  registered: burst in progress
aux_rvalid  out  1  burst beat data valid
aux_rdata  out  DW  burst beat data
aux_done  out  1  pulses with the final beat's aux_rvalid
ram_addr  out  AW  to SPRAM ADDRESS
ram_wdata  out  DW  to SPRAM DATAIN
ram_wren  out  1  to SPRAM WREN
ram_maskwren  out  4  to SPRAM MASKWREN
ram_cs  out  1  to SPRAM CHIPSELECT; high only in a used slot
ram_rdata  in  DW  from SPRAM DATAOUT; valid the cycle after an issued read

Behaviour:
- Reset values: state IDLE; aux_busy, cpu_rvalid, aux_rvalid, aux_done = 0; the address counter, beat counter and last-slot flag = 0.
- Combinational outputs are 0 whenever their request inputs are 0.
- States:
  - IDLE: no burst. aux_gnt = aux_req. On aux_gnt, latch aux_addr into acnt and aux_len into bcnt, then go to BURST next cycle. cpu_gnt = cpu_req.
  - BURST: every cycle issues either a burst beat or a CPU access.
    - With CPU_PRIO=0: cpu_gnt = cpu_req && last slot was a burst beat. Otherwise a beat issues.
    - With CPU_PRIO=1: cpu_gnt = cpu_req, and the beat stalls.
    - A beat drives ram_addr=acnt, ram_wren=0, mask=0. It then increments acnt (mod 2^AW, 0x3FFF wraps to 0x0000) and decrements bcnt.
    - The beat issued with bcnt==0 is the last. The state returns to IDLE the next cycle.
  - aux_req is ignored while in BURST (aux_gnt=0).
- CPU slot: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_wren=cpu_we, ram_maskwren = cpu_we ? cpu_mask : 0.
- Read return: cpu_rvalid and aux_rvalid are registered copies of "read issued for X" (CPU writes produce no rvalid). cpu_rdata and aux_rdata = ram_rdata, passed through. aux_done is registered alongside the last beat's rvalid.
- Slot precedence in the same cycle as IDLE→BURST acceptance: the CPU still gets that slot. The first beat issues no earlier than the following cycle.
- aux_busy = (state==BURST).
- Reset mid-burst: burst aborted, no aux_done, pending rvalid dropped.
- ram_cs = cpu_gnt || beat issued.

Decomposition:
- Shared package: AW/DW defaults, state encoding (IDLE, BURST), SPRAM mask width constant.
- One sub-module is natural: dataram_burst_gen, holding the acnt/bcnt counters, the last-beat flag and wrap logic. Arbitration, muxing and return tagging stay in the top.

Test Plan:
1. CPU write 0xBEEF @0x0010 mask 0xF, then read @0x0010 → cpu_gnt the same cycle each time; cpu_rvalid 1 cycle after the read with cpu_rdata=0xBEEF; no rvalid for the write.
2. Burst addr 0x3FFE, len 3, CPU idle → four beats at 0x3FFE, 0x3FFF, 0x0000, 0x0001 on consecutive cycles; aux_done with the 4th aux_rvalid; aux_busy high for 4 cycles.
3. CPU_PRIO=0, burst len 7 with cpu_req held high for continuous reads → slots alternate beat/CPU; 8 beats complete within 16 cycles; no beat skipped or duplicated.
4. CPU_PRIO=1, same stimulus → beats stall while cpu_req is high; they resume at the same acnt when cpu_req drops.
5. aux_req and cpu_req asserted together in IDLE → cpu_gnt=1 and aux_gnt=1 the same cycle; first beat the next cycle; a second aux_req during BURST sees aux_gnt=0.
6. nreset asserted mid-burst (after 2 of 8 beats) → all outputs 0 immediately, no aux_done; after release, a new burst from 0x0100 len 0 returns one beat with aux_done.
